cond_flag_unit: RTL

- Execute-stage consumer of the ALU's {N,Z,C,V} flag vector.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates the PCSrc/RegWrite/MemWrite controls and updates the flags under FlagW.
- Also provides the carry-in for ADC/SBC and two saturating counters: executed and squashed instructions.

---
 rtl/cond_flag_unit_pkg.sv | 34 +++
 rtl/cond_flag_unit_cond_check.sv | 42 ++++
 rtl/cond_flag_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the condition/flag unit: ARM condition codes,
// NZCV bit positions and FlagW encodings.
package cond_flag_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_CV   = 2'b01;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;
    localparam int FLAGW_NZ_BIT = 1;
    localparam int FLAGW_CV_BIT = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Combinational ARM condition evaluation of a 4-bit condition field
// against an NZCV flag vector.
module cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v, ge;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Execute-stage condition unit: architectural NZCV register, condition
// gating of PC/register/memory writes, and executed/squashed counters.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             Valid,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CarryIn,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;
    logic             act;
    logic             upd;
    logic             cnt_en;

    // Condition is judged on the registered flags only: no ALUFlags bypass.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    // Stall does not gate controls (downstream holds); it only blocks state updates.
    assign act    = Valid & ~Flush & CondEx;
    assign upd    = act & ~Stall;
    assign cnt_en = Valid & ~Stall & ~Flush;

    assign PCSrc    = PCS & act;
    assign RegWrite = RegW & ~NoWrite & act;
    assign MemWrite = MemW & act;
    assign Flags    = flags_q;
    assign CarryIn  = flags_q[FLAG_C];
    assign ExecCnt  = exec_q;
    assign SquashCnt = squash_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            flags_q <= FLAGS_RST;
        end else if (upd) begin
            if (FlagW[FLAGW_NZ_BIT]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FLAGW_CV_BIT]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Saturating counters; a clear beats a same-cycle increment.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (CntClr) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (cnt_en) begin
            if (CondEx) begin
                if (exec_q != '1) exec_q <= exec_q + CNT_W'(1);
            end else begin
                if (squash_q != '1) squash_q <= squash_q + CNT_W'(1);
            end
        end
    end

endmodule
